// File: rtl/nmi_rr_arb_if.sv
// Native memory interface (NMI) bundle shared by the arbiter and its slave.
// The master side drives the request fields. The slave answers with ready/rdata.
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

// File: rtl/nmi_rr_arb.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MSTR requesters.
// A granted request is latched into holding registers and presented downstream
// until the slave returns ready. The response is then steered back to the
// granted master only, and the rotating pointer moves past it.
// Optional watchdog: define NMI_RR_ARB_TIMEOUT_EN. A transaction that is not
// completed within TIMEOUT_CYC busy cycles is then terminated with 32'hDEAD_BEEF.
module nmi_rr_arb #(
    parameter int NUM_MSTR    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_MSTR-1:0]         m_valid_i,
    input  logic [NUM_MSTR*32-1:0]      m_addr_i,
    input  logic [NUM_MSTR*32-1:0]      m_wdata_i,
    input  logic [NUM_MSTR*4-1:0]       m_wstrb_i,
    output logic [NUM_MSTR-1:0]         m_ready_o,
    output logic [NUM_MSTR*32-1:0]      m_rdata_o,
    nmi_if.master                       nmi,
    output logic [$clog2(NUM_MSTR)-1:0] grant_o,
    output logic                        busy_o,
    output logic                        tmo_o
);

    localparam int GW = $clog2(NUM_MSTR);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [GW-1:0] ptr_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] req_idx;
    logic          req_found;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          done;
    logic          expire;
    logic          timeout_hit;

    // Pick the first requester at or after the rotating pointer, wrapping around
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 0; i < NUM_MSTR; i++) begin
            if (!req_found && m_valid_i[(int'(ptr_q) + i) % NUM_MSTR]) begin
                req_found = 1'b1;
                req_idx   = GW'((int'(ptr_q) + i) % NUM_MSTR);
            end
        end
    end

`ifdef NMI_RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] tmo_cnt_q;

    // Watchdog counter: held at zero outside BUSY, counts busy cycles without ready
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != BUSY) begin
            tmo_cnt_q <= '0;
        end else if (!nmi.ready) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, plus the completion qualifiers (slave ready wins over watchdog)
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (nmi.ready) begin
                    done = 1'b1;
                end else if (timeout_hit) begin
                    expire = 1'b1;
                end
                if (nmi.ready || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's request on the IDLE->BUSY edge; advance the pointer on completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (state_q == IDLE && req_found) begin
                grant_q <= req_idx;
                addr_q  <= m_addr_i[32*req_idx +: 32];
                wdata_q <= m_wdata_i[32*req_idx +: 32];
                wstrb_q <= m_wstrb_i[4*req_idx +: 4];
            end
            if (done || expire) begin
                ptr_q <= (grant_q == GW'(NUM_MSTR - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    // Steer the completion pulse and read data to the granted master only
    always_comb begin
        m_ready_o = '0;
        m_rdata_o = '0;
        if (done || expire) begin
            m_ready_o[grant_q]            = 1'b1;
            m_rdata_o[32*grant_q +: 32]   = done ? nmi.rdata : 32'hDEAD_BEEF;
        end
    end

    assign nmi.valid = (state_q == BUSY);
    assign nmi.addr  = addr_q;
    assign nmi.wdata = wdata_q;
    assign nmi.wstrb = wstrb_q;
    assign busy_o    = (state_q == BUSY);
    assign grant_o   = grant_q;

`ifdef NMI_RR_ARB_TIMEOUT_EN
    assign tmo_o = expire;
`else
    assign tmo_o = 1'b0;
`endif

endmodule

// File: tb/tb_nmi_rr_arb.sv
// Self-checking bench for nmi_rr_arb with two masters.
// It has three parts:
//   - directed sequences for the corner cases;
//   - a table of arbitration vectors;
//   - randomized traffic checked against a transaction-level reference model.
module tb_nmi_rr_arb;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_valid;
    logic [N*32-1:0] m_addr;
    logic [N*32-1:0] m_wdata;
    logic [N*4-1:0]  m_wstrb;
    logic [N-1:0]    m_ready;
    logic [N*32-1:0] m_rdata;
    logic [0:0]      grant;
    logic            busy;
    logic            tmo;

    nmi_if nmi ();

    nmi_rr_arb #(.NUM_MSTR(N), .TIMEOUT_CYC(TMO)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .m_valid_i (m_valid),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_wstrb_i (m_wstrb),
        .m_ready_o (m_ready),
        .m_rdata_o (m_rdata),
        .nmi       (nmi),
        .grant_o   (grant),
        .busy_o    (busy),
        .tmo_o     (tmo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] rdata;
        int          exp_grant;
    } vec_t;

    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        m_valid    = '0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wstrb    = '0;
        nmi.ready  = 1'b0;
        nmi.rdata  = '0;
        #1;
        check_output("rst_valid", nmi.valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_mready", m_ready, 0);
        check_output("rst_grant", grant, 0);
        check_output("rst_addr", nmi.addr, 0);
        check_output("rst_tmo", tmo, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction from a table record; every requester gets a distinct address
    task automatic apply_stimulus(input vec_t v);
        logic [63:0] exp_rd;
        tick();
        m_valid = v.valid;
        for (int k = 0; k < N; k++) begin
            m_addr[32*k +: 32]  = 32'hA000_0000 | (k << 4);
            m_wdata[32*k +: 32] = 32'h5000_0000 | k;
            m_wstrb[4*k +: 4]   = 4'(k + 1);
        end
        @(negedge clk);
        check_output("vec_idle_valid", nmi.valid, 0);
        tick();
        @(negedge clk);
        check_output("vec_busy", busy, 1);
        check_output("vec_grant", grant, v.exp_grant);
        check_output("vec_addr", nmi.addr, 32'hA000_0000 | (v.exp_grant << 4));
        check_output("vec_wstrb", nmi.wstrb, v.exp_grant + 1);
        check_output("vec_early_ready", m_ready, 0);
        tick();
        nmi.ready = 1'b1;
        nmi.rdata = v.rdata;
        @(negedge clk);
        exp_rd = '0;
        exp_rd[32*v.exp_grant +: 32] = v.rdata;
        check_output("vec_mready", m_ready, 64'(1) << v.exp_grant);
        check_output("vec_rdata", m_rdata, exp_rd);
        tick();
        nmi.ready = 1'b0;
        m_valid   = '0;
        @(negedge clk);
        check_output("vec_done_busy", busy, 0);
        check_output("vec_done_mready", m_ready, 0);
    endtask

    // Transaction-level reference model state for the random phase
    bit          mdl_busy;
    int          mdl_grant;
    int          mdl_ptr;
    int          mdl_bcnt;
    logic [31:0] mdl_addr;
    logic [31:0] mdl_wdata;
    logic [3:0]  mdl_wstrb;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin
        logic [63:0] exp_rd;
        int          done_k;
        int          eg;
        bit          exp_exp;
        bit          found;
        int          k;

        vecs[0] = '{2'b01, 32'h1111_0000, 0};
        vecs[1] = '{2'b11, 32'h2222_0001, 1};
        vecs[2] = '{2'b11, 32'h3333_0002, 0};
        vecs[3] = '{2'b01, 32'h4444_0003, 0};
        vecs[4] = '{2'b10, 32'h5555_0004, 1};
        vecs[5] = '{2'b10, 32'h6666_0005, 1};
        vecs[6] = '{2'b11, 32'h7777_0006, 0};

        do_reset();

        // Single read from master 0, slave answers in the third busy cycle
        tick();
        m_valid              = 2'b01;
        m_addr[31:0]         = 32'h1000_1004;
        m_wstrb[3:0]         = 4'h0;
        @(negedge clk);
        check_output("rd_valid_latency", nmi.valid, 0);
        tick();
        @(negedge clk);
        check_output("rd_valid", nmi.valid, 1);
        check_output("rd_addr", nmi.addr, 32'h1000_1004);
        check_output("rd_wstrb", nmi.wstrb, 0);
        check_output("rd_grant", grant, 0);
        tick();
        @(negedge clk);
        check_output("rd_wait_mready", m_ready, 0);
        tick();
        nmi.ready = 1'b1;
        nmi.rdata = 32'h1234_5678;
        @(negedge clk);
        check_output("rd_mready", m_ready, 2'b01);
        check_output("rd_rdata", m_rdata, {32'h0, 32'h1234_5678});
        tick();
        nmi.ready = 1'b0;
        m_valid   = '0;
        @(negedge clk);
        check_output("rd_pulse_len", m_ready, 0);
        check_output("rd_rdata_zero", m_rdata, 0);
        check_output("rd_grant_hold", grant, 0);

        // Write from master 1 whose inputs change while it is granted
        tick();
        m_valid         = 2'b10;
        m_addr[63:32]   = 32'h4000_0010;
        m_wdata[63:32]  = 32'hCAFE_F00D;
        m_wstrb[7:4]    = 4'hF;
        tick();
        m_addr[63:32]   = 32'h9999_9999;
        m_wdata[63:32]  = 32'h0BAD_0BAD;
        @(negedge clk);
        check_output("wr_grant", grant, 1);
        check_output("wr_addr", nmi.addr, 32'h4000_0010);
        check_output("wr_wdata", nmi.wdata, 32'hCAFE_F00D);
        check_output("wr_wstrb", nmi.wstrb, 4'hF);
        tick();
        @(negedge clk);
        check_output("wr_addr_hold", nmi.addr, 32'h4000_0010);
        check_output("wr_wdata_hold", nmi.wdata, 32'hCAFE_F00D);
        tick();
        nmi.ready = 1'b1;
        nmi.rdata = 32'h0;
        @(negedge clk);
        check_output("wr_mready", m_ready, 2'b10);
        tick();
        nmi.ready = 1'b0;
        m_valid   = '0;

        // Stray ready while idle
        tick();
        nmi.ready = 1'b1;
        nmi.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_output("stray_mready", m_ready, 0);
        check_output("stray_rdata", m_rdata, 0);
        tick();
        @(negedge clk);
        check_output("stray_busy", busy, 0);
        check_output("stray_mready2", m_ready, 0);
        tick();
        nmi.ready = 1'b0;
        @(negedge clk);

        // Both masters requesting continuously with an always-ready slave (ptr is 0 here)
        tick();
        m_valid   = 2'b11;
        nmi.ready = 1'b1;
        @(negedge clk);
        check_output("rot_first_idle", busy, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            nmi.rdata = $urandom;
            if (c == 7) m_valid = '0;
            @(negedge clk);
            if (c % 2 == 0) begin
                eg = (c / 2) % 2;
                exp_rd = '0;
                exp_rd[32*eg +: 32] = nmi.rdata;
                check_output("rot_busy", busy, 1);
                check_output("rot_grant", grant, eg);
                check_output("rot_mready", m_ready, 64'(1) << eg);
                check_output("rot_rdata", m_rdata, exp_rd);
            end else begin
                check_output("rot_gap_busy", busy, 0);
                check_output("rot_gap_mready", m_ready, 0);
            end
        end
        tick();
        nmi.ready = 1'b0;

        // Table of arbitration vectors from a clean reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset asserted mid-transaction; the pointer is moved to 1 first
        do_reset();
        apply_stimulus(vecs[0]);
        tick();
        m_valid = 2'b10;
        tick();
        @(negedge clk);
        check_output("midrst_busy_before", busy, 1);
        check_output("midrst_grant_before", grant, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", nmi.valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_mready", m_ready, 0);
        check_output("midrst_grant", grant, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 2'b11;
        tick();
        @(negedge clk);
        check_output("midrst_first_grant", grant, 0);
        check_output("midrst_first_busy", busy, 1);
        tick();
        nmi.ready = 1'b1;
        m_valid   = '0;
        tick();
        nmi.ready = 1'b0;

`ifdef NMI_RR_ARB_TIMEOUT_EN
        // Watchdog: silent slave, then a ready arriving exactly in the expiry cycle
        do_reset();
        tick();
        m_valid = 2'b11;
        @(negedge clk);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            @(negedge clk);
            if (c < TMO) begin
                check_output("wd_wait_mready", m_ready, 0);
                check_output("wd_wait_tmo", tmo, 0);
            end else begin
                check_output("wd_mready", m_ready, 2'b01);
                check_output("wd_tmo", tmo, 1);
                check_output("wd_rdata", m_rdata, {32'h0, 32'hDEAD_BEEF});
            end
        end
        tick();
        @(negedge clk);
        check_output("wd_after_busy", busy, 0);
        check_output("wd_after_tmo", tmo, 0);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (c == TMO) begin
                nmi.ready = 1'b1;
                nmi.rdata = 32'h55AA_33CC;
            end
            @(negedge clk);
            if (c == 1) check_output("wd_next_grant", grant, 1);
            if (c == TMO) begin
                check_output("wd2_mready", m_ready, 2'b10);
                check_output("wd2_tmo", tmo, 0);
                check_output("wd2_rdata", m_rdata, {32'h55AA_33CC, 32'h0});
            end
        end
        tick();
        nmi.ready = 1'b0;
        m_valid   = '0;
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        mdl_busy  = 1'b0;
        mdl_grant = 0;
        mdl_ptr   = 0;
        mdl_bcnt  = 0;
        mdl_addr  = '0;
        mdl_wdata = '0;
        mdl_wstrb = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            done_k = -1;
            if (mdl_busy) begin
                exp_exp = 1'b0;
`ifdef NMI_RR_ARB_TIMEOUT_EN
                exp_exp = (mdl_bcnt == TMO) && !nmi.ready;
`endif
                if (nmi.ready || exp_exp) begin
                    done_k   = mdl_grant;
                    mdl_ptr  = (mdl_grant + 1) % N;
                    mdl_busy = 1'b0;
                end else begin
                    mdl_bcnt++;
                end
            end else begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    k = (mdl_ptr + i) % N;
                    if (!found && m_valid[k]) begin
                        found     = 1'b1;
                        mdl_busy  = 1'b1;
                        mdl_grant = k;
                        mdl_bcnt  = 1;
                        mdl_addr  = m_addr[32*k +: 32];
                        mdl_wdata = m_wdata[32*k +: 32];
                        mdl_wstrb = m_wstrb[4*k +: 4];
                    end
                end
            end
            #1;
            for (int m = 0; m < N; m++) begin
                if (m == done_k) begin
                    m_valid[m] = ($urandom_range(1, 0) == 1);
                end else if (!m_valid[m]) begin
                    m_valid[m] = ($urandom_range(2, 0) == 0);
                end
                if ($urandom_range(4, 0) == 0 || m == done_k) begin
                    m_addr[32*m +: 32]  = $urandom;
                    m_wdata[32*m +: 32] = $urandom;
                    m_wstrb[4*m +: 4]   = 4'($urandom);
                end
            end
            nmi.ready = ($urandom_range(2, 0) == 0);
            nmi.rdata = $urandom;
            @(negedge clk);
            exp_exp = 1'b0;
`ifdef NMI_RR_ARB_TIMEOUT_EN
            exp_exp = mdl_busy && (mdl_bcnt == TMO) && !nmi.ready;
`endif
            exp_rd = '0;
            if (mdl_busy && (nmi.ready || exp_exp)) begin
                exp_rd[32*mdl_grant +: 32] = exp_exp ? 32'hDEAD_BEEF : nmi.rdata;
                check_output("rnd_mready", m_ready, 64'(1) << mdl_grant);
            end else begin
                check_output("rnd_mready", m_ready, 0);
            end
            check_output("rnd_rdata", m_rdata, exp_rd);
            check_output("rnd_valid", nmi.valid, mdl_busy);
            check_output("rnd_busy", busy, mdl_busy);
            check_output("rnd_grant", grant, mdl_grant);
            check_output("rnd_tmo", tmo, exp_exp);
            if (mdl_busy) begin
                check_output("rnd_addr", nmi.addr, mdl_addr);
                check_output("rnd_wdata", nmi.wdata, mdl_wdata);
                check_output("rnd_wstrb", nmi.wstrb, mdl_wstrb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
